// File: rtl/judge_pkg.sv
// Shared types and default constants for the rhythm-game note judge.
//   state_t    : top-level play state (IDLE / PLAY / RESULT)
//   judgment_t : outcome decided for the current cycle
//   DEF_*      : default parameter values used by note_judge
//   sat_inc8   : saturating increment for 8-bit counters (combo)
package judge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAY,
    ST_RESULT
  } state_t;

  typedef enum logic [1:0] {
    J_NONE,
    J_HIT,
    J_STRAY,
    J_MISS
  } judgment_t;

  localparam int DEF_SYNC_STAGES  = 2;
  localparam int DEF_HIT_POINTS   = 10;
  localparam int DEF_BONUS_POINTS = 5;
  localparam int DEF_BONUS_COMBO  = 10;
  localparam int DEF_CNT_W        = 11;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/note_judge_if.sv
// Link between the chart scroller and the note judge.
//   note_R_judge / note_B_judge : colour flags of the note in the judge row
//   note_shift                  : one-cycle pulse, row shifts at end of cycle
//   finish                      : chart has ended
//   delete                      : one-cycle pulse from the judge, clears the row note
// master = scroller side, slave = judge side.
interface note_judge_if;

  logic note_R_judge;
  logic note_B_judge;
  logic note_shift;
  logic finish;
  logic delete;

  modport master (
    output note_R_judge, note_B_judge, note_shift, finish,
    input  delete
  );

  modport slave (
    input  note_R_judge, note_B_judge, note_shift, finish,
    output delete
  );

endinterface

// File: rtl/btn_sync_edge.sv
// Button synchronizer with rising-edge detector.
//   clk, rst : system clock, asynchronous active-high reset
//   raw      : asynchronous button level
//   press    : registered one-cycle pulse, high SYNC_STAGES+1 cycles after
//              the raw rise (SYNC_STAGES must be at least 2)
module btn_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   last;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, giving a true shift chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= '0;
      last  <= 1'b0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], raw};
      last  <= sync[SYNC_STAGES-1];
      press <= sync[SYNC_STAGES-1] & ~last;
    end
  end

endmodule

// File: rtl/note_judge.sv
// Player-side judge for the rhythm-game lanes.
// Decides HIT / STRAY / MISS per note, pulses delete for hit notes and keeps
// the result-screen statistics.
//   clk, rst                 : system clock, asynchronous active-high reset
//   start                    : song selected (level)
//   ack, red_btn, blue_btn   : raw player buttons
//   link (slave)             : judge-row flags, note_shift, finish in; delete out
//   combo, max_combo         : current / best run of consecutive hits (sat. 255)
//   hit_cnt, miss_cnt        : saturating hit / miss counts
//   score                    : saturating points
//   busy, result_valid       : high in PLAY / RESULT
module note_judge
  import judge_pkg::*;
#(
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int HIT_POINTS   = DEF_HIT_POINTS,
  parameter int BONUS_POINTS = DEF_BONUS_POINTS,
  parameter int BONUS_COMBO  = DEF_BONUS_COMBO,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ack,
  input  logic             red_btn,
  input  logic             blue_btn,
  note_judge_if.slave      link,
  output logic [7:0]       combo,
  output logic [7:0]       max_combo,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic [15:0]      score,
  output logic             busy,
  output logic             result_valid
);

  localparam logic [16:0] HIT_ADD   = 17'(HIT_POINTS);
  localparam logic [16:0] BONUS_ADD = 17'(HIT_POINTS + BONUS_POINTS);

  logic red_press, blue_press, ack_press;

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_red_sync (
    .clk(clk), .rst(rst), .raw(red_btn), .press(red_press)
  );
  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_blue_sync (
    .clk(clk), .rst(rst), .raw(blue_btn), .press(blue_press)
  );
  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
    .clk(clk), .rst(rst), .raw(ack), .press(ack_press)
  );

  state_t    state;
  judgment_t judgment;

  // Epoch bookkeeping: which colours appeared in the row since the last
  // shift, whether that row was already hit, and a press deferred across
  // a shift.
  logic seen_r, seen_b, hit_done;
  logic pend_r, pend_b;

  logic        eff_r, eff_b, row_seen, epoch_end;
  logic [7:0]  combo_next;
  logic [16:0] score_sum;
  logic [15:0] score_next;

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    eff_r      = pend_r | red_press;
    eff_b      = pend_b | blue_press;
    row_seen   = seen_r | seen_b | link.note_R_judge | link.note_B_judge;
    epoch_end  = link.note_shift | link.finish;
    combo_next = sat_inc8(combo);
    score_sum  = {1'b0, score} + ((combo >= 8'(BONUS_COMBO)) ? BONUS_ADD : HIT_ADD);
    score_next = score_sum[16] ? 16'hFFFF : score_sum[15:0];
    judgment   = J_NONE;
    if (state == ST_PLAY) begin
      if (epoch_end) begin
        // Presses are never judged on a shift or finish cycle, so MISS is
        // the only outcome possible here.
        if (row_seen && !hit_done) judgment = J_MISS;
      end else if (eff_r || eff_b) begin
        if (!hit_done && ((eff_r && !eff_b && link.note_R_judge) ||
                          (eff_b && !eff_r && link.note_B_judge)))
          judgment = J_HIT;
        else
          judgment = J_STRAY;
      end
    end
  end

  // NOTE: all state, including statistics, is cleared by the asynchronous
  // reset; there is no memory array here that would be left unreset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      link.delete  <= 1'b0;
      combo        <= '0;
      max_combo    <= '0;
      hit_cnt      <= '0;
      miss_cnt     <= '0;
      score        <= '0;
      seen_r       <= 1'b0;
      seen_b       <= 1'b0;
      hit_done     <= 1'b0;
      pend_r       <= 1'b0;
      pend_b       <= 1'b0;
    end else begin
      link.delete <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_PLAY;
            busy      <= 1'b1;
            combo     <= '0;
            max_combo <= '0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
            score     <= '0;
            seen_r    <= 1'b0;
            seen_b    <= 1'b0;
            hit_done  <= 1'b0;
            pend_r    <= 1'b0;
            pend_b    <= 1'b0;
          end
        end

        ST_PLAY: begin
          if (link.finish) begin
            state        <= ST_RESULT;
            busy         <= 1'b0;
            result_valid <= 1'b1;
          end

          // The next row is only sampled from the cycle after the shift.
          if (epoch_end) begin
            seen_r   <= 1'b0;
            seen_b   <= 1'b0;
            hit_done <= 1'b0;
          end else begin
            seen_r <= seen_r | link.note_R_judge;
            seen_b <= seen_b | link.note_B_judge;
          end

          // A press landing on a shift is held one cycle and judged against
          // the new row; the scroller favours delete over the shift, so the
          // deferred hit still clears the right note. Finish drops it.
          if (link.note_shift && !link.finish) begin
            pend_r <= eff_r;
            pend_b <= eff_b;
          end else begin
            pend_r <= 1'b0;
            pend_b <= 1'b0;
          end

          case (judgment)
            J_HIT: begin
              link.delete <= 1'b1;
              hit_done    <= 1'b1;
              if (hit_cnt != {CNT_W{1'b1}}) hit_cnt <= hit_cnt + CNT_W'(1);
              combo <= combo_next;
              if (combo_next > max_combo) max_combo <= combo_next;
              score <= score_next;
            end
            J_STRAY: combo <= '0;
            J_MISS: begin
              if (miss_cnt != {CNT_W{1'b1}}) miss_cnt <= miss_cnt + CNT_W'(1);
              combo <= '0;
            end
            default: ;
          endcase
        end

        ST_RESULT: begin
          if (ack_press) begin
            state        <= ST_IDLE;
            result_valid <= 1'b0;
          end
        end

        default: begin
          state        <= ST_IDLE;
          busy         <= 1'b0;
          result_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_judge.sv
// Self-checking bench for note_judge: directed scenarios with expected
// constants, then randomized play compared every cycle against an
// event-level reference model of the judging rules.
module tb_note_judge;

  logic        clk = 1'b0;
  logic        rst, start, ack, red_btn, blue_btn;
  logic [7:0]  combo, max_combo;
  logic [10:0] hit_cnt, miss_cnt;
  logic [15:0] score;
  logic        busy, result_valid;

  note_judge_if link();

  note_judge dut (
    .clk(clk), .rst(rst), .start(start), .ack(ack),
    .red_btn(red_btn), .blue_btn(blue_btn), .link(link),
    .combo(combo), .max_combo(max_combo), .hit_cnt(hit_cnt),
    .miss_cnt(miss_cnt), .score(score), .busy(busy),
    .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Stimulus for the next clock edge.
  bit d_start, d_finish, d_nr, d_nb, d_shift, d_red, d_blue, d_ack;

  // Reference model (mode: 0 idle, 1 play, 2 result).
  int m_mode, m_combo, m_max, m_hits, m_miss, m_score;
  bit m_seen, m_done, m_pr, m_pb, m_del;
  int edge_no = 0;
  int rq[$], bq[$], aq[$];
  bit p_red, p_blue, p_ack;

  localparam int PRESS_LAT = 3;  // raw rise -> press judged at this many edges later

  task automatic model_reset();
    m_mode = 0; m_combo = 0; m_max = 0; m_hits = 0; m_miss = 0; m_score = 0;
    m_seen = 0; m_done = 0; m_pr = 0; m_pb = 0; m_del = 0;
    rq.delete(); bq.delete(); aq.delete();
    p_red = 0; p_blue = 0; p_ack = 0;
  endtask

  task automatic model_edge();
    bit pr, pb, pa, er, eb, row;
    int pts;
    pr = 0; pb = 0; pa = 0;
    if (rq.size() != 0 && rq[0] == edge_no) begin pr = 1; rq.delete(0); end
    if (bq.size() != 0 && bq[0] == edge_no) begin pb = 1; bq.delete(0); end
    if (aq.size() != 0 && aq[0] == edge_no) begin pa = 1; aq.delete(0); end
    m_del = 0;
    case (m_mode)
      0: if (d_start) begin
        m_mode = 1; m_combo = 0; m_max = 0; m_hits = 0; m_miss = 0; m_score = 0;
        m_seen = 0; m_done = 0; m_pr = 0; m_pb = 0;
      end
      1: begin
        row = m_seen || d_nr || d_nb;
        er  = m_pr || pr;
        eb  = m_pb || pb;
        if (d_finish || d_shift) begin
          if (row && !m_done) begin
            if (m_miss < 2047) m_miss++;
            m_combo = 0;
          end
          m_seen = 0; m_done = 0;
          m_pr = d_finish ? 1'b0 : er;
          m_pb = d_finish ? 1'b0 : eb;
          if (d_finish) m_mode = 2;
        end else begin
          m_seen = row; m_pr = 0; m_pb = 0;
          if (er || eb) begin
            if (er != eb && !m_done && (er ? d_nr : d_nb)) begin
              m_del = 1; m_done = 1;
              if (m_hits < 2047) m_hits++;
              pts = (m_combo >= 10) ? 15 : 10;
              m_score = (m_score + pts > 65535) ? 65535 : m_score + pts;
              if (m_combo < 255) m_combo++;
              if (m_combo > m_max) m_max = m_combo;
            end else begin
              m_combo = 0;
            end
          end
        end
      end
      default: if (pa) m_mode = 0;
    endcase
  endtask

  // One clock: apply stimulus, take the edge, advance the model, settle.
  task automatic tick();
    start = d_start; ack = d_ack; red_btn = d_red; blue_btn = d_blue;
    link.finish = d_finish; link.note_shift = d_shift;
    link.note_R_judge = d_nr; link.note_B_judge = d_nb;
    if (d_red  && !p_red)  rq.push_back(edge_no + 1 + PRESS_LAT);
    if (d_blue && !p_blue) bq.push_back(edge_no + 1 + PRESS_LAT);
    if (d_ack  && !p_ack)  aq.push_back(edge_no + 1 + PRESS_LAT);
    p_red = d_red; p_blue = d_blue; p_ack = d_ack;
    @(posedge clk);
    edge_no++;
    model_edge();
    #1;
  endtask

  task automatic clear_drive();
    d_start = 0; d_finish = 0; d_nr = 0; d_nb = 0; d_shift = 0;
    d_red = 0; d_blue = 0; d_ack = 0;
    start = 0; ack = 0; red_btn = 0; blue_btn = 0;
    link.finish = 0; link.note_shift = 0; link.note_R_judge = 0; link.note_B_judge = 0;
  endtask

  task automatic do_reset();
    clear_drive();
    rst = 1'b1;
    model_reset();
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic start_song();
    d_start = 1; tick(); d_start = 0;
  endtask

  // Raw press held for one cycle, then n cycles total; reports deletes seen.
  task automatic press(input bit r, input bit b, input bit a, input int n,
                       output int dels, output int first_del);
    dels = 0; first_del = 0;
    d_red = r; d_blue = b; d_ack = a;
    for (int i = 1; i <= n; i++) begin
      tick();
      d_red = 0; d_blue = 0; d_ack = 0;
      if (link.delete === 1'b1) begin
        dels++;
        if (first_del == 0) first_del = i;
      end
    end
  endtask

  task automatic shift_tick();
    d_shift = 1; tick(); d_shift = 0;
  endtask

  // Red note in the row, hit it, clear the row and close the epoch.
  task automatic hit_red();
    int dels, fd;
    d_nr = 1;
    press(1, 0, 0, 4, dels, fd);
    d_nr = 0;
    shift_tick();
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({combo, max_combo, hit_cnt, miss_cnt, score, busy, result_valid, link.delete} !== '0) begin
      bad++; $display("FAIL reset_init: got %h want 0",
        {combo, max_combo, hit_cnt, miss_cnt, score, busy, result_valid, link.delete});
    end
    release_reset();
    start_song();
    repeat (7) hit_red();
    total++;
    if (combo !== 8'd7 || score !== 16'd70) begin
      bad++; $display("FAIL reset_setup: combo=%0d score=%0d want 7/70", combo, score);
    end
    do_reset();
    total++;
    if ({combo, max_combo, hit_cnt, miss_cnt, score, busy, result_valid, link.delete} !== '0) begin
      bad++; $display("FAIL reset_async: got %h want 0",
        {combo, max_combo, hit_cnt, miss_cnt, score, busy, result_valid, link.delete});
    end
    release_reset();
    begin
      int dels, fd;
      d_nr = 1;
      press(1, 0, 0, 6, dels, fd);
      d_nr = 0;
      total++;
      if (dels !== 0 || busy !== 1'b0) begin
        bad++; $display("FAIL reset_idle_press: deletes=%0d busy=%0b want 0/0", dels, busy);
      end
    end
  endtask

  task automatic test_single_hit();
    int dels, fd;
    do_reset(); release_reset();
    start_song();
    total++;
    if (busy !== 1'b1 || result_valid !== 1'b0) begin
      bad++; $display("FAIL start_busy: busy=%0b rv=%0b want 1/0", busy, result_valid);
    end
    d_nr = 1;
    press(1, 0, 0, 7, dels, fd);
    d_nr = 0;
    total++;
    if (dels !== 1 || fd !== 4) begin
      bad++; $display("FAIL hit_delete: count=%0d at=%0d want 1 at 4", dels, fd);
    end
    shift_tick();
    total++;
    if (hit_cnt !== 11'd1 || combo !== 8'd1 || score !== 16'd10 || miss_cnt !== 11'd0) begin
      bad++; $display("FAIL hit_counts: hit=%0d combo=%0d score=%0d miss=%0d want 1/1/10/0",
        hit_cnt, combo, score, miss_cnt);
    end
  endtask

  task automatic test_bonus();
    do_reset(); release_reset(); start_song();
    repeat (10) hit_red();
    total++;
    if (score !== 16'd100 || combo !== 8'd10) begin
      bad++; $display("FAIL bonus_ten: score=%0d combo=%0d want 100/10", score, combo);
    end
    hit_red();
    total++;
    if (score !== 16'd115 || combo !== 8'd11 || max_combo !== 8'd11) begin
      bad++; $display("FAIL bonus_eleven: score=%0d combo=%0d max=%0d want 115/11/11",
        score, combo, max_combo);
    end
  endtask

  task automatic test_miss();
    int dels, fd;
    do_reset(); release_reset(); start_song();
    repeat (5) hit_red();
    d_nb = 1;
    tick(); tick();
    shift_tick();
    d_nb = 0;
    total++;
    if (miss_cnt !== 11'd1 || combo !== 8'd0 || max_combo !== 8'd5) begin
      bad++; $display("FAIL miss_epoch: miss=%0d combo=%0d max=%0d want 1/0/5",
        miss_cnt, combo, max_combo);
    end
    d_nr = 1;
    press(1, 0, 0, 4, dels, fd);
    d_nr = 0;
    press(1, 0, 0, 5, dels, fd);
    total++;
    if (dels !== 0 || combo !== 8'd0 || hit_cnt !== 11'd6) begin
      bad++; $display("FAIL stray_cleared_row: deletes=%0d combo=%0d hit=%0d want 0/0/6",
        dels, combo, hit_cnt);
    end
  endtask

  task automatic test_deferred();
    int dels, fd;
    do_reset(); release_reset(); start_song();
    d_nr = 1;
    press(1, 0, 0, 4, dels, fd);
    d_nr = 0;
    tick();
    d_blue = 1; tick(); d_blue = 0;
    tick(); tick();
    d_shift = 1; tick(); d_shift = 0;
    total++;
    if (link.delete !== 1'b0) begin
      bad++; $display("FAIL defer_on_shift: delete=%0b want 0", link.delete);
    end
    d_nb = 1; tick();
    total++;
    if (link.delete !== 1'b1) begin
      bad++; $display("FAIL defer_hit: delete=%0b want 1", link.delete);
    end
    d_nb = 0; tick();
    total++;
    if (hit_cnt !== 11'd2 || miss_cnt !== 11'd0 || combo !== 8'd2 || link.delete !== 1'b0) begin
      bad++; $display("FAIL defer_counts: hit=%0d miss=%0d combo=%0d del=%0b want 2/0/2/0",
        hit_cnt, miss_cnt, combo, link.delete);
    end
  endtask

  task automatic test_both_result();
    int dels, fd;
    do_reset(); release_reset(); start_song();
    hit_red();
    d_nr = 1;
    press(1, 1, 0, 6, dels, fd);
    total++;
    if (dels !== 0 || combo !== 8'd0) begin
      bad++; $display("FAIL both_stray: deletes=%0d combo=%0d want 0/0", dels, combo);
    end
    d_finish = 1; tick(); d_finish = 0; d_nr = 0;
    total++;
    if (result_valid !== 1'b1 || busy !== 1'b0 || miss_cnt !== 11'd1 || hit_cnt !== 11'd1) begin
      bad++; $display("FAIL finish_result: rv=%0b busy=%0b miss=%0d hit=%0d want 1/0/1/1",
        result_valid, busy, miss_cnt, hit_cnt);
    end
    d_nr = 1;
    press(1, 0, 0, 5, dels, fd);
    d_nr = 0;
    total++;
    if (dels !== 0 || hit_cnt !== 11'd1 || score !== 16'd10 || max_combo !== 8'd1) begin
      bad++; $display("FAIL result_hold: del=%0d hit=%0d score=%0d max=%0d want 0/1/10/1",
        dels, hit_cnt, score, max_combo);
    end
    press(0, 0, 1, 4, dels, fd);
    total++;
    if (result_valid !== 1'b0 || busy !== 1'b0 || hit_cnt !== 11'd1 || miss_cnt !== 11'd1) begin
      bad++; $display("FAIL ack_idle: rv=%0b busy=%0b hit=%0d miss=%0d want 0/0/1/1",
        result_valid, busy, hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_saturate();
    do_reset(); release_reset(); start_song();
    repeat (260) hit_red();
    total++;
    if (combo !== 8'd255 || max_combo !== 8'd255 || hit_cnt !== 11'd260 || score !== 16'd3850) begin
      bad++; $display("FAIL combo_sat: combo=%0d max=%0d hit=%0d score=%0d want 255/255/260/3850",
        combo, max_combo, hit_cnt, score);
    end
  endtask

  task automatic test_random();
    int ep_left;
    bit was_shift;
    logic [56:0] got, want;
    do_reset(); release_reset();
    ep_left = 3;
    for (int c = 0; c < 3000; c++) begin
      d_start  = (m_mode == 0) && ($urandom_range(0, 9) == 0);
      d_finish = (m_mode == 1) && ($urandom_range(0, 249) == 0);
      ep_left--;
      d_shift  = (ep_left <= 0);
      if (d_shift) ep_left = $urandom_range(2, 7);
      if (d_red || d_blue) begin
        d_red = 0; d_blue = 0;
      end else begin
        case ($urandom_range(0, 11))
          0, 1:    d_red = 1;
          2, 3:    d_blue = 1;
          4:       begin d_red = 1; d_blue = 1; end
          default: ;
        endcase
      end
      d_ack = d_ack ? 1'b0 : ($urandom_range(0, 7) == 0);
      was_shift = d_shift;
      tick();
      want = {m_del, 8'(m_combo), 8'(m_max), 11'(m_hits), 11'(m_miss), 16'(m_score),
              m_mode == 1, m_mode == 2};
      got  = {link.delete, combo, max_combo, hit_cnt, miss_cnt, score, busy, result_valid};
      total++;
      if (got !== want) begin
        bad++; $display("FAIL random_cycle %0d: got %h want %h", c, got, want);
      end
      if (was_shift) begin
        case ($urandom_range(0, 3))
          0: begin d_nr = 1; d_nb = 0; end
          1: begin d_nr = 0; d_nb = 1; end
          2: begin d_nr = 1; d_nb = 1; end
          default: begin d_nr = 0; d_nb = 0; end
        endcase
      end else if (m_del) begin
        d_nr = 0; d_nb = 0;
      end
    end
    clear_drive();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_hit();
    test_bonus();
    test_miss();
    test_deferred();
    test_both_result();
    test_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/note_judge.md
Name: note_judge

Overview:
- Player-side judge for the rhythm-game lanes. It consumes the judge-row colour flags and per-step shift pulses from the chart scroller, and the player's red/blue buttons.
- It decides hit, miss or stray for each note.
- It issues the one-cycle `delete` pulse that clears a hit note from the judge row.
- It maintains combo, max combo, hit/miss counts and score for the result screen.

Parameters:
- SYNC_STAGES, 2, flip-flop stages in each button synchronizer
- HIT_POINTS, 10, score added per hit
- BONUS_POINTS, 5, extra score per hit when pre-hit combo >= BONUS_COMBO
- BONUS_COMBO, 10, combo threshold for the bonus
- CNT_W, 11, width of hit_cnt/miss_cnt

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  level; song selected (nonzero song code)
- finish  in  1  chart-end indication from the scroller
- ack  in  1  raw yellow button; leaves the result screen
- red_btn  in  1  raw red button
- blue_btn  in  1  raw blue button
- note_R_judge  in  1  red note present in the judge row
- note_B_judge  in  1  blue note present in the judge row
- note_shift  in  1  one-cycle pulse; the note_range shift occurs at the end of this cycle
- delete  out  1  one-cycle pulse; clears the judge-row note
- combo  out  8  current consecutive hits, saturating at 255
- max_combo  out  8  highest combo this song
- hit_cnt  out  CNT_W  hits, saturating
- miss_cnt  out  CNT_W  misses, saturating
- score  out  16  points, saturating at 65535
- busy  out  1  high in PLAY
- result_valid  out  1  high in RESULT

Behaviour:
- Reset (async, `rst` = 1): state IDLE; all outputs 0; synchronizers, epoch flags and pending register cleared.
- Button inputs: red, blue and ack each pass through an SYNC_STAGES-deep synchronizer plus a rising-edge detector. A press is a 1-cycle edge pulse, available SYNC_STAGES+1 cycles after the raw rise.
- FSM, IDLE -> PLAY: on `start` = 1. On that transition clear combo, max_combo, hit_cnt, miss_cnt, score, the epoch flags and the pending press.
- FSM, PLAY -> RESULT: on `finish` = 1. Run the epoch-end check (below) in that same cycle.
- FSM, RESULT -> IDLE: on an ack press. Counters hold their values through RESULT and IDLE until the next start.
- Presses outside PLAY are ignored.
- Epoch: the interval between note_shift pulses.
  - Each cycle in PLAY: `seen_R |= note_R_judge`, `seen_B |= note_B_judge`.
  - `hit_done` is set when a hit is taken.
- Press evaluation in PLAY, on a cycle with note_shift = 0, using the current judge flags:
  - Red press only, note_R_judge = 1, hit_done = 0 -> HIT.
  - Blue press only, note_B_judge = 1, hit_done = 0 -> HIT.
  - Any other press -> STRAY. This includes red and blue pressed in the same cycle, a wrong colour, an empty row, or hit_done already set.
- HIT actions:
  - `delete` = 1 on the next cycle (registered, 1-cycle latency).
  - hit_done <= 1; hit_cnt += 1.
  - combo += 1, saturating.
  - max_combo <= max(max_combo, new combo).
  - score += HIT_POINTS, plus BONUS_POINTS if the pre-hit combo >= BONUS_COMBO; saturate at 65535.
- STRAY actions: combo <= 0. No count changes and no delete.
- Press coincident with note_shift: stored in a one-deep pending register and evaluated on the following cycle against the new epoch.
  - This is required because the scroller gives delete priority over the shift.
  - A new press in that following cycle ORs with the pending one. Red and blue together -> STRAY.
- Epoch end (note_shift = 1, or the finish cycle): if `(seen_R | seen_B)` and !hit_done -> MISS.
  - MISS actions: miss_cnt += 1, combo <= 0.
  - Epoch flags are then cleared. If note_shift, `seen_*` is loaded with 0 (the next row is sampled from the next cycle).
- Flags held high by the `delete` latency do not re-trigger a hit, because hit_done stays set.
- A HIT and a MISS cannot both fall in one cycle, since presses are deferred on note_shift cycles.
- If `finish` coincides with a pending press, the press is discarded.
- `delete` never asserts outside PLAY or in the cycle after reset release.

Decomposition:
- Package `judge_pkg`:
  - State encoding IDLE/PLAY/RESULT.
  - Judgment enum NONE/HIT/STRAY/MISS.
  - Default scoring constants.
- Sub-module `btn_sync_edge` (synchronizer + rising-edge detect, parameter SYNC_STAGES): instantiated three times, for red, blue and ack.

Test Plan:
- Reset mid-PLAY with combo = 7, score = 70 -> all outputs 0 immediately and state IDLE; a red press afterwards yields no delete.
- start, red note in row, one red press -> delete pulses exactly once, SYNC_STAGES+2 cycles after the raw rise; hit_cnt = 1, combo = 1, score = 10.
- Ten consecutive red hits, then an eleventh -> score after the eleventh = 10·10 + 15 = 115; combo = 11; max_combo = 11.
- Blue note in row, no press, note_shift pulse -> miss_cnt = 1, combo 5 -> 0, max_combo stays 5; a second press in the same epoch on a cleared row counts as STRAY.
- Press edge coincident with note_shift while the next row holds a blue note, blue pressed -> hit on the new note one cycle later; no miss for the old epoch if it was already hit.
- Red and blue pressed in the same cycle with a red note present -> combo = 0, no delete; then finish -> RESULT, result_valid = 1, counts hold; ack press -> IDLE.
